// File: rtl/enc_pkg.sv
// Shared SEC-DED layout for the 32-bit encoder and its matching decoder:
// widths, data-index-to-position mapping and parity coverage masks.
package enc_pkg;
   localparam int DATA_W = 32;
   localparam int PAR_W  = 6;
   localparam int HAM_W  = 38;
   localparam int CODE_W = 39;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [CODE_W-1:0] code_t;

   // Hamming position (1..38) of data bit idx: the idx-th non-power-of-two position.
   function automatic int data_pos(input int idx);
      int n;
      int pos;
      n   = 0;
      pos = 0;
      for (int p = 1; p <= HAM_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == idx) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

   // Data bits that feed the parity bit at position 2^k.
   function automatic data_t cover_mask(input int k);
      data_t m;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (((data_pos(i) >> k) & 1) == 1) m[i] = 1'b1;
      end
      return m;
   endfunction
endpackage

// File: rtl/enc_core.sv
// Combinational SEC-DED encode: scatters data into Hamming positions,
// fills the six parity positions, and appends overall parity at bit 38.
module enc_core
   import enc_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   output logic [CODE_W-1:0] o_code
);
   logic [HAM_W-1:0] w_ham;

   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
         localparam int POS = data_pos(gi);
         assign w_ham[POS-1] = i_data[gi];
      end
      for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
         localparam data_t MASK = cover_mask(gi);
         assign w_ham[(1 << gi) - 1] = ^(i_data & MASK);
      end
   endgenerate

   assign o_code = {^w_ham, w_ham};
endmodule

// File: rtl/enc_top.sv
// SEC-DED encoder top. Define ENC_TOP_OUT_REG_EN to register OUT (1-cycle
// latency, synchronous reset to the all-zero codeword); otherwise OUT is combinational.
module enc_top
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] IN,
   output logic [CODE_W-1:0] OUT
);
   logic [CODE_W-1:0] w_code;

   enc_core u_core (
      .i_data (IN),
      .o_code (w_code)
   );

`ifdef ENC_TOP_OUT_REG_EN
   logic [CODE_W-1:0] r_code;

   // Zero is a legal codeword, so reset never exposes an uncorrectable word.
   always_ff @(posedge clk) begin
      if (rst) r_code <= '0;
      else     r_code <= w_code;
   end

   assign OUT = r_code;
`else
   logic w_unused;
   assign w_unused = &{1'b0, clk, rst};
   assign OUT      = w_code;
`endif
endmodule

// File: tb/tb_enc_top.sv
// Scoreboard bench for enc_top: stimulus queues expected codewords, a monitor
// compares them and checks SEC-DED properties (weight, syndrome, 1/2-bit flips).
module tb_enc_top;
   logic        clk;
   logic        rst;
   logic [31:0] IN;
   logic [38:0] OUT;

`ifdef ENC_TOP_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int          due;
      logic [38:0] exp;
      logic [31:0] din;
      string       nm;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc;
   int          checks;
   int          errors;
   logic [37:0] cov[6];

   enc_top dut (
      .clk (clk),
      .rst (rst),
      .IN  (IN),
      .OUT (OUT)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: scatter data, then parity bits = XOR of the positions of all set data bits.
   function automatic logic [38:0] ref_enc(input logic [31:0] d);
      logic [38:0] w;
      int n;
      int syn;
      w   = '0;
      n   = 0;
      syn = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            w[p-1] = d[n];
            if (d[n]) syn = syn ^ p;
            n++;
         end
      end
      for (int k = 0; k < 6; k++) w[(1 << k) - 1] = syn[k];
      w[38] = ^w[37:0];
      return w;
   endfunction

   function automatic logic [5:0] syndrome(input logic [38:0] w);
      logic [5:0] s;
      for (int k = 0; k < 6; k++) s[k] = ^(w[37:0] & cov[k]);
      return s;
   endfunction

   task automatic drive(input logic [31:0] d, input logic r, input logic [38:0] exp, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      IN    = d;
      rst   = r;
      e.due = cyc + LAT;
      e.exp = exp;
      e.din = d;
      e.nm  = nm;
      sb_q.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t        e;
      logic [38:0] w;
      logic [38:0] f;
      logic [5:0]  s;
      bit          ok;
      for (int k = 0; k < 6; k++) begin
         cov[k] = '0;
         for (int p = 1; p <= 38; p++) if (((p >> k) & 1) == 1) cov[k][p-1] = 1'b1;
      end
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            w = OUT;
            checks++;
            if (e.due != cyc || w !== e.exp) begin
               errors++;
               $display("FAIL %s in=%h got=%h want=%h (cycle %0d due %0d)", e.nm, e.din, w, e.exp, cyc, e.due);
            end
            checks++;
            if ((^w) !== 1'b0) begin
               errors++;
               $display("FAIL %s_weight in=%h got parity=%b want=0", e.nm, e.din, ^w);
            end
            checks++;
            s = syndrome(w);
            if (s !== 6'd0) begin
               errors++;
               $display("FAIL %s_syndrome in=%h got=%0d want=0", e.nm, e.din, s);
            end
            ok = 1'b1;
            for (int i = 0; i < 39; i++) begin
               f = w ^ (39'd1 << i);
               s = syndrome(f);
               if (s !== ((i == 38) ? 6'd0 : 6'(i + 1)) || (^f) !== 1'b1) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
               errors++;
               $display("FAIL %s_single_flip in=%h got=%h want=syndrome equal to flip position, odd parity", e.nm, e.din, w);
            end
            ok = 1'b1;
            for (int i = 0; i < 39; i++) begin
               for (int j = i + 1; j < 39; j++) begin
                  f = w ^ (39'd1 << i) ^ (39'd1 << j);
                  s = syndrome(f);
                  if (s == 6'd0 || (^f) !== 1'b0) ok = 1'b0;
               end
            end
            checks++;
            if (!ok) begin
               errors++;
               $display("FAIL %s_double_flip in=%h got=%h want=nonzero syndrome, even parity", e.nm, e.din, w);
            end
            $display("txn %-10s in=%h out=%h exp=%h", e.nm, e.din, w, e.exp);
         end
      end
   end

   // Stimulus
   initial begin
      logic [31:0] d;
      logic [31:0] vec[4];
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      IN     = 32'h0;
      vec[0] = 32'd1979398776;
      vec[1] = 32'd1010226197;
      vec[2] = 32'd3597602390;
      vec[3] = 32'd4270230797;

`ifdef ENC_TOP_OUT_REG_EN
      drive(32'hFFFF_FFFF, 1'b1, 39'h0, "rst_hold0");
      drive(32'hFFFF_FFFF, 1'b1, 39'h0, "rst_hold1");
      drive(32'hFFFF_FFFF, 1'b0, 39'h3F_7FFF_FFF4, "rst_release");
`endif
      drive(32'h0000_0000, 1'b0, 39'h00_0000_0000, "zero");
      drive(32'h0000_0001, 1'b0, 39'h40_0000_0007, "bit0");
      drive(32'h8000_0000, 1'b0, 39'h20_8000_000A, "bit31");
      drive(32'hFFFF_FFFF, 1'b0, 39'h3F_7FFF_FFF4, "ones");
`ifdef ENC_TOP_OUT_REG_EN
      drive(32'h0000_0001, 1'b0, 39'h40_0000_0007, "pre_rst");
      drive(32'hFFFF_FFFF, 1'b1, 39'h0, "mid_rst");
      drive(32'h8000_0000, 1'b0, 39'h20_8000_000A, "post_rst");
`endif
      for (int i = 0; i < 4; i++) drive(vec[i], 1'b0, ref_enc(vec[i]), "listed");
      for (int i = 0; i < 10000; i++) begin
         d = $urandom();
         drive(d, 1'b0, ref_enc(d), "random");
      end

      for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending want=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/enc_top.md
# enc_top

SEC-DED (single-error-correct, double-error-detect) encoder for a 32-bit data word. It produces a 39-bit extended-Hamming codeword: 32 data bits, 6 Hamming parity bits and 1 overall parity bit. It sits on the write path ahead of protected storage and pairs with the matching SEC-DED decoder, which uses the same bit layout.

## Interface
- No parameters. Widths are fixed: data 32, Hamming parity 6, codeword 39.
- One clock; reset is synchronous and active-high.
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset; only used when the output register is enabled
- IN  input  32  data word to encode
- OUT  output  39  encoded codeword

## Operation
- Codeword position numbering:
  - Hamming positions p = 1..38 map to OUT[p-1].
  - OUT[38] is the overall parity bit.
- Hamming parity positions are 1, 2, 4, 8, 16 and 32.
- Data placement:
  - Data occupies the non-power-of-two positions 3, 5, 6, 7, 9–15, 17–31 and 33–38, in ascending order.
  - IN[0] goes to position 3, IN[1] to position 5, and so on up to IN[31] at position 38.
- Hamming parity at position 2^k (k = 0..5) is the XOR of all data-bearing positions whose index has bit k set. This is even parity.
- Overall parity: OUT[38] = XOR of OUT[37:0], so the full 39-bit word always has even weight.
- The encoder is purely combinational from IN to the pre-register codeword. There is no state and no handshake; a new word may be presented every cycle.
- Encoding IN = 0 gives OUT = 0. The all-zero word is a valid codeword.

## Timing
- Without the output register (default): OUT depends combinationally on IN with zero latency. clk and rst have no effect.
- With the output register:
  - OUT is registered on the rising edge of clk, giving 1-cycle latency.
  - When rst is high at a rising edge, OUT resets to 39'h0 on that edge. Zero is a valid codeword, so downstream logic never sees an invalid word out of reset.
  - Reset has priority over new data in the same cycle.
  - Deasserting rst resumes encoding on the next edge: the word present during the first cycle with rst low appears on the following edge.
- Back-to-back inputs are supported in both modes with throughput of 1 word per cycle.

## Configuration
- Macro: ENC_TOP_OUT_REG_EN.
- Defined: a 39-bit output register with synchronous reset is inserted after the encode logic, as described under Timing.
- Undefined: OUT is driven directly by the encode logic, and clk and rst are unconnected internally.
- The codeword layout is identical in both modes.

## Structure
- Shared package enc_pkg holds:
  - constants DATA_W = 32, PAR_W = 6, CODE_W = 39;
  - a function or constant table mapping data index to Hamming position;
  - the parity-coverage masks.
- The matching decoder imports the same package so that both sides use one layout.
- One natural sub-module, enc_core: purely combinational, IN[31:0] in and codeword[38:0] out. enc_top wraps it and adds the optional register.

## Test plan
- Zero word: IN = 32'h0 → OUT = 39'h00_0000_0000.
- Single data bit, low end: IN = 32'h0000_0001 → OUT = 39'h40_0000_0007.
  - Position 3 is set, parities at positions 1 and 2 are set, and the overall parity bit is set.
- Single data bit, high end: IN = 32'h8000_0000 → OUT = 39'h20_8000_000A.
  - Position 38 is set, parities at positions 2, 4 and 32 are set, and the overall parity bit is 0.
- All ones: IN = 32'hFFFF_FFFF → OUT = 39'h3F_7FFF_FFF4.
- Random sweep of at least 10k words (include IN = 1979398776, 1010226197, 3597602390 and 4270230797). For each word, compare against a reference model and check:
  - the 39-bit word has even weight;
  - the 6-bit syndrome is 0;
  - every single-bit flip yields the syndrome equal to the flipped position with odd overall parity;
  - every double-bit flip yields a nonzero syndrome with even overall parity.
- Registered mode (ENC_TOP_OUT_REG_EN defined):
  - Hold rst high for 2 cycles with IN = 32'hFFFF_FFFF → OUT = 0.
  - Release rst → OUT = 39'h3F_7FFF_FFF4 one edge later.
  - Assert rst mid-stream → OUT = 0 on that edge.
